// File: rtl/tile_index_sequencer.sv
// tile_index_sequencer: walks the (i, j, l) block-index space of C = A x B.
// For each output block (i, j) it emits A(i,l), B(l,j) for every l, then
// C(i,j). Requests go out on a registered valid/ready handshake.
module tile_index_sequencer #(
  parameter int index_width = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic [31:0]            i_Config,
  input  logic                   i_Ready,
  output logic                   o_Valid,
  output logic [index_width-1:0] o_Row_Index,
  output logic [index_width-1:0] o_Column_Index,
  output logic [2:0]             o_Type,
  output logic                   o_Last_Term,
  output logic                   o_Busy,
  output logic                   o_Done
);

  typedef enum logic [2:0] {IDLE, EMIT_A, EMIT_B, EMIT_C, DONE} state_t;

  localparam logic [2:0]             T_A = 3'b001;
  localparam logic [2:0]             T_B = 3'b010;
  localparam logic [2:0]             T_C = 3'b100;
  localparam logic [index_width-1:0] ONE = index_width'(1);
  localparam logic [index_width-1:0] ZERO = '0;

  state_t                 state;
  logic [index_width-1:0] mu_q, gamma_q, lambda_q;
  logic [index_width-1:0] i_q, j_q, l_q;
  logic [index_width-1:0] cfg_mu, cfg_gamma, cfg_lambda;
  logic                   unused_cfg;
  logic                   xfer, l_end, j_end, i_end;

  assign cfg_mu     = index_width'(i_Config[23:16]);
  assign cfg_gamma  = index_width'(i_Config[15:8]);
  assign cfg_lambda = index_width'(i_Config[7:0]);
  assign unused_cfg = ^i_Config[31:24];

  // Counters compare against dim-1 so dim = 2^index_width-1 never wraps.
  assign xfer  = o_Valid & i_Ready;
  assign l_end = (l_q == mu_q - ONE);
  assign j_end = (j_q == gamma_q - ONE);
  assign i_end = (i_q == lambda_q - ONE);

  // Walk FSM; every output is a register loaded with the next request.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state          <= IDLE;
      mu_q           <= '0;
      gamma_q        <= '0;
      lambda_q       <= '0;
      i_q            <= '0;
      j_q            <= '0;
      l_q            <= '0;
      o_Valid        <= 1'b0;
      o_Row_Index    <= '0;
      o_Column_Index <= '0;
      o_Type         <= '0;
      o_Last_Term    <= 1'b0;
      o_Busy         <= 1'b0;
      o_Done         <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: if (i_Start) begin
          mu_q     <= cfg_mu;
          gamma_q  <= cfg_gamma;
          lambda_q <= cfg_lambda;
          i_q      <= '0;
          j_q      <= '0;
          l_q      <= '0;
          o_Busy   <= 1'b1;
          if (cfg_mu == ZERO || cfg_gamma == ZERO || cfg_lambda == ZERO) begin
            // Empty product: no requests, just the completion pulse.
            state  <= DONE;
            o_Done <= 1'b1;
          end else begin
            state          <= EMIT_A;
            o_Valid        <= 1'b1;
            o_Row_Index    <= '0;
            o_Column_Index <= '0;
            o_Type         <= T_A;
            o_Last_Term    <= (cfg_mu == ONE);
          end
        end
        EMIT_A: if (xfer) begin
          // B(l, j) pairs with the A(i, l) just accepted; same l, same last flag.
          state          <= EMIT_B;
          o_Row_Index    <= l_q;
          o_Column_Index <= j_q;
          o_Type         <= T_B;
        end
        EMIT_B: if (xfer) begin
          if (!l_end) begin
            state          <= EMIT_A;
            l_q            <= l_q + ONE;
            o_Row_Index    <= i_q;
            o_Column_Index <= l_q + ONE;
            o_Type         <= T_A;
            o_Last_Term    <= (l_q + ONE == mu_q - ONE);
          end else begin
            state          <= EMIT_C;
            l_q            <= '0;
            o_Row_Index    <= i_q;
            o_Column_Index <= j_q;
            o_Type         <= T_C;
            o_Last_Term    <= 1'b0;
          end
        end
        EMIT_C: if (xfer) begin
          if (!j_end) begin
            state          <= EMIT_A;
            j_q            <= j_q + ONE;
            o_Row_Index    <= i_q;
            o_Column_Index <= '0;
            o_Type         <= T_A;
            o_Last_Term    <= (mu_q == ONE);
          end else if (!i_end) begin
            state          <= EMIT_A;
            j_q            <= '0;
            i_q            <= i_q + ONE;
            o_Row_Index    <= i_q + ONE;
            o_Column_Index <= '0;
            o_Type         <= T_A;
            o_Last_Term    <= (mu_q == ONE);
          end else begin
            // Index/type outputs keep their last value; o_Valid qualifies them.
            state   <= DONE;
            j_q     <= '0;
            o_Valid <= 1'b0;
            o_Done  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_index_sequencer.sv
// Bench for tile_index_sequencer: a reference walk is queued at start and
// popped by a negedge monitor on each handshake; tasks check timing/counts.
module tb_tile_index_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Reset, i_Start, i_Ready;
  logic [31:0] i_Config;
  logic        o_Valid, o_Last_Term, o_Busy, o_Done;
  logic [7:0]  o_Row_Index, o_Column_Index;
  logic [2:0]  o_Type;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [2:0] typ;
    logic       last;
  } req_t;

  req_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          xfer_cnt = 0;
  bit          prev_stall = 0;
  logic [20:0] prev_out;

  tile_index_sequencer #(.index_width(8)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Config(i_Config),
    .i_Ready(i_Ready), .o_Valid(o_Valid), .o_Row_Index(o_Row_Index),
    .o_Column_Index(o_Column_Index), .o_Type(o_Type), .o_Last_Term(o_Last_Term),
    .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference walk: plain nested loops in i, j, l order.
  task automatic push_walk(input int mu, input int g, input int lam);
    req_t r;
    for (int i = 0; i < lam; i++)
      for (int j = 0; j < g; j++) begin
        for (int l = 0; l < mu; l++) begin
          r.row = 8'(i); r.col = 8'(l); r.typ = 3'b001; r.last = (l == mu - 1);
          exp_q.push_back(r);
          r.row = 8'(l); r.col = 8'(j); r.typ = 3'b010; r.last = (l == mu - 1);
          exp_q.push_back(r);
        end
        r.row = 8'(i); r.col = 8'(j); r.typ = 3'b100; r.last = 1'b0;
        exp_q.push_back(r);
      end
  endtask

  // Scoreboard monitor: compares each accepted request and stall stability.
  always @(negedge i_Clk) begin
    req_t act, e;
    if (i_Reset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        n_checks++;
        if ({o_Row_Index, o_Column_Index, o_Type, o_Last_Term, o_Valid} !== prev_out) begin
          n_errors++;
          $display("FAIL stall_hold got=%h want=%h",
                   {o_Row_Index, o_Column_Index, o_Type, o_Last_Term, o_Valid}, prev_out);
        end
      end
      if (o_Valid && i_Ready) begin
        xfer_cnt++;
        act = {o_Row_Index, o_Column_Index, o_Type, o_Last_Term};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_xfer got=%h want=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_errors++;
            $display("FAIL xfer_%0d got row=%0d col=%0d typ=%b last=%b want row=%0d col=%0d typ=%b last=%b",
                     xfer_cnt, act.row, act.col, act.typ, act.last, e.row, e.col, e.typ, e.last);
          end
        end
      end
      prev_stall = o_Valid && !i_Ready;
      prev_out   = {o_Row_Index, o_Column_Index, o_Type, o_Last_Term, o_Valid};
    end
  end

  // Drives one walk; reports cycles from the start edge to o_Done and status after.
  task automatic run_walk(input int mu, input int g, input int lam, input bit rnd, input bit spam,
                          output int cycles, output bit done_seen, output bit busy_ok,
                          output bit busy_after, output bit done_after, output int nvalid);
    push_walk(mu, g, lam);
    xfer_cnt  = 0;
    done_seen = 0;
    busy_ok   = 1;
    nvalid    = 0;
    cycles    = 0;
    @(posedge i_Clk); #1;
    i_Config = {8'hA5, 8'(mu), 8'(g), 8'(lam)};
    i_Start  = 1'b1;
    i_Ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge i_Clk); #1;
    i_Start  = spam;
    i_Config = $urandom;
    i_Ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      @(negedge i_Clk);
      cycles++;
      if (o_Valid) nvalid++;
      if (!o_Busy) busy_ok = 0;
      if (o_Done) begin done_seen = 1; break; end
      if (cycles > 5000) break;
      @(posedge i_Clk); #1;
      i_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_Start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    i_Start = spam;   // high across the DONE-cycle edge when spamming
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    @(negedge i_Clk);
    busy_after = o_Busy;
    done_after = o_Done;
  endtask

  task automatic test_reset();
    @(negedge i_Clk);
    n_checks++;
    if ({o_Valid, o_Row_Index, o_Column_Index, o_Type, o_Last_Term, o_Busy, o_Done} !== 23'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {o_Valid, o_Row_Index, o_Column_Index, o_Type, o_Last_Term, o_Busy, o_Done});
    end
  endtask

  task automatic test_walk(input string name, input int mu, input int g, input int lam,
                           input bit rnd, input bit spam);
    int cyc, nv; bit ds, bok, ba, da;
    int want = lam * g * (2 * mu + 1);
    run_walk(mu, g, lam, rnd, spam, cyc, ds, bok, ba, da, nv);
    n_checks++;
    if (!ds) begin n_errors++; $display("FAIL %s done_seen got=0 want=1", name); end
    n_checks++;
    if (xfer_cnt != want) begin n_errors++; $display("FAIL %s xfer_count got=%0d want=%0d", name, xfer_cnt, want); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL %s leftover got=%0d want=0", name, exp_q.size()); end
    if (!rnd) begin
      n_checks++;
      if (cyc != want + 1) begin n_errors++; $display("FAIL %s done_cycle got=%0d want=%0d", name, cyc, want + 1); end
      n_checks++;
      if (nv != want) begin n_errors++; $display("FAIL %s valid_cycles got=%0d want=%0d", name, nv, want); end
    end
    n_checks++;
    if (!bok) begin n_errors++; $display("FAIL %s busy_during got=0 want=1", name); end
    n_checks++;
    if ({ba, da} !== 2'b00) begin n_errors++; $display("FAIL %s after_done busy/done got=%b want=00", name, {ba, da}); end
    exp_q.delete();
  endtask

  task automatic test_zero_dim();
    int cyc, nv; bit ds, bok, ba, da;
    run_walk(3, 2, 0, 1'b0, 1'b0, cyc, ds, bok, ba, da, nv);
    n_checks++;
    if (cyc != 1 || !ds) begin n_errors++; $display("FAIL zero_dim done_cycle got=%0d want=1", cyc); end
    n_checks++;
    if (nv != 0) begin n_errors++; $display("FAIL zero_dim valid_cycles got=%0d want=0", nv); end
    n_checks++;
    if ({ba, da} !== 2'b00) begin n_errors++; $display("FAIL zero_dim after_done got=%b want=00", {ba, da}); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_walk();
    int n;
    bit bad;
    push_walk(2, 2, 2);
    xfer_cnt = 0;
    @(posedge i_Clk); #1;
    i_Config = 32'h0002_0202; i_Start = 1'b1; i_Ready = 1'b1;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    n = 0;
    while (xfer_cnt < 4 && n < 100) begin @(negedge i_Clk); n++; end
    n_checks++;
    if (xfer_cnt != 4) begin n_errors++; $display("FAIL midreset_reach4 got=%0d want=4", xfer_cnt); end
    @(posedge i_Clk); #1;
    i_Reset = 1'b1;
    @(posedge i_Clk); #1;
    test_reset();
    i_Reset = 1'b0;
    exp_q.delete();
    bad = 0;
    repeat (5) begin
      @(negedge i_Clk);
      if (o_Done || o_Valid || o_Busy) bad = 1;
    end
    n_checks++;
    if (bad) begin n_errors++; $display("FAIL midreset_quiet got=activity want=idle"); end
    test_walk("restart", 2, 2, 2, 1'b0, 1'b0);
  endtask

  initial begin
    i_Reset = 1'b1; i_Start = 1'b0; i_Ready = 1'b0; i_Config = '0;
    repeat (2) @(posedge i_Clk);
    #1;
    test_reset();
    i_Reset = 1'b0;
    test_walk("single_1x1x1", 1, 1, 1, 1'b0, 1'b0);
    test_walk("order_2x2x1", 2, 2, 1, 1'b0, 1'b0);
    test_walk("stall_2x2x1", 2, 2, 1, 1'b1, 1'b0);
    test_walk("stall_3x2x3", 3, 2, 3, 1'b1, 1'b0);
    test_zero_dim();
    test_reset_mid_walk();
    test_walk("start_spam", 2, 3, 2, 1'b0, 1'b1);
    test_walk("start_spam_rnd", 3, 1, 2, 1'b1, 1'b1);
    test_walk("mu_255", 255, 1, 1, 1'b0, 1'b0);
    test_walk("lambda_255", 1, 1, 255, 1'b0, 1'b0);
    test_walk("gamma_255", 1, 255, 1, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
